// File: rtl/press_classifier.sv
// Classifies debounced button presses as short or long and holds one event
// for a consumer; a second event arriving while one is unacknowledged is dropped.
module press_classifier #(
   parameter logic [15:0] LONG_CYCLES = 16'd50000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       debounced,
   input  logic       ack,
   output logic       evt_valid,
   output logic       evt_long,
   output logic [7:0] press_count,
   output logic       overflow
);

   typedef enum logic [1:0] {IDLE, PRESSED, HELD} state_t;

   // Last counter value before the classifying sample; the rise sample counts as the first high sample.
   localparam logic [15:0] LONG_LAST = LONG_CYCLES - 16'd2;

   state_t      state_reg, state_next;
   logic [15:0] count_reg, count_next;
   logic        d_q;
   logic        rise;
   logic        gen_evt;
   logic        gen_long;

   logic        evt_valid_next;
   logic        evt_long_next;
   logic [7:0]  press_count_next;
   logic        overflow_next;

   assign rise = debounced & ~d_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg <= IDLE;
         count_reg <= 16'd0;
         d_q       <= 1'b0;
      end else begin
         state_reg <= state_next;
         count_reg <= count_next;
         d_q       <= debounced;
      end
   end

   always_comb begin
      state_next = state_reg;
      count_next = count_reg;
      gen_evt    = 1'b0;
      gen_long   = 1'b0;
      case (state_reg)
         IDLE: begin
            if (rise) begin
               state_next = PRESSED;
               count_next = 16'd0;
            end
         end
         PRESSED: begin
            if (!debounced) begin
               gen_evt    = 1'b1;
               state_next = IDLE;
            end else if (count_reg == LONG_LAST) begin
               gen_evt    = 1'b1;
               gen_long   = 1'b1;
               state_next = HELD;
            end else begin
               count_next = count_reg + 16'd1;
            end
         end
         HELD: begin
            if (!debounced) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Event slot: an ack on the same edge as a new event frees the slot for it.
   always_comb begin
      evt_valid_next   = evt_valid;
      evt_long_next    = evt_long;
      press_count_next = press_count;
      overflow_next    = overflow;
      if (gen_evt) begin
         if (!evt_valid || ack) begin
            evt_valid_next   = 1'b1;
            evt_long_next    = gen_long;
            press_count_next = press_count + 8'd1;
         end else begin
            overflow_next = 1'b1;
         end
      end else if (evt_valid && ack) begin
         evt_valid_next = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         evt_valid   <= 1'b0;
         evt_long    <= 1'b0;
         press_count <= 8'd0;
         overflow    <= 1'b0;
      end else begin
         evt_valid   <= evt_valid_next;
         evt_long    <= evt_long_next;
         press_count <= press_count_next;
         overflow    <= overflow_next;
      end
   end

endmodule
